// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_pkg
// Brief    : Shared types and golden-function helper for the gate BIST.
// Revision : 1.0 - initial release
// ============================================================================
package gate_bist_pkg;

    localparam int c_max_n = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FUNC_OR  = 2'd0,
        FUNC_AND = 2'd1,
        FUNC_XOR = 2'd2,
        FUNC_NOR = 2'd3
    } func_e;

    // Only the low n bits of v take part; upper bits are ignored.
    function automatic logic golden(func_e f, logic [7:0] v, int n);
        logic w_any;
        logic w_all;
        logic w_par;
        w_any = 1'b0;
        w_all = 1'b1;
        w_par = 1'b0;
        for (int i = 0; i < c_max_n; i++) begin
            if (i < n) begin
                w_any = w_any | v[i];
                w_all = w_all & v[i];
                w_par = w_par ^ v[i];
            end
        end
        case (f)
            FUNC_OR:  return w_any;
            FUNC_AND: return w_all;
            FUNC_XOR: return w_par;
            default:  return ~w_any;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_bist_golden.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_golden
// Brief    : Combinational reference evaluator for the gate under test.
// Revision : 1.0 - initial release
// ============================================================================
module gate_bist_golden
    import gate_bist_pkg::*;
#(
    parameter int N    = 4,
    parameter int FUNC = 0
) (
    input  logic [N-1:0] stim,
    output logic         expected
);

    localparam func_e c_func = func_e'(FUNC[1:0]);

    logic [7:0] w_vec;

    always_comb begin
        w_vec          = '0;
        w_vec[N-1:0]   = stim;
        expected       = golden(c_func, w_vec, N);
    end

endmodule
`default_nettype wire

// File: rtl/gate_bist.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist
// Brief    : BIST sequencer that sweeps every N-bit pattern into a small gate,
//            compares dut_y against a golden function and counts mismatches.
//            Optional first-failure log enabled by macro GATE_BIST_LOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int N             = 4,
    parameter int FUNC          = 0,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N-1:0]     stim,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef GATE_BIST_LOG_EN
    ,
    output logic [N-1:0]     first_fail_pat,
    output logic             first_fail_vld
`endif
);

    localparam int                 c_cnt_w       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [N-1:0]       c_stim_max    = {N{1'b1}};
    localparam logic [ERR_W-1:0]   c_err_max     = {ERR_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_stim;
    logic [ERR_W-1:0]   r_err;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_expected;
    logic               w_mismatch;
    logic               w_start_ok;
    logic               w_last_pat;

    gate_bist_golden #(
        .N    (N),
        .FUNC (FUNC)
    ) u_golden (
        .stim     (r_stim),
        .expected (w_expected)
    );

    // Case inequality so an unknown dut_y is a mismatch; synthesis sees plain !=.
    assign w_mismatch = (dut_y !== w_expected);
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_pat = (r_stim == c_stim_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = APPLY;
            APPLY:   w_state_nxt = SETTLE;
            SETTLE:  if (r_cnt == '0) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = w_last_pat ? DONE : APPLY;
            DONE:    if (start) w_state_nxt = APPLY;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stim <= '0;
            r_err  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_stim <= '0;
                    r_err  <= '0;
                end
                APPLY: begin
                    r_cnt <= c_settle_load;
                end
                SETTLE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                CHECK: begin
                    if (w_mismatch && (r_err != c_err_max)) r_err <= r_err + 1'b1;
                    if (!w_last_pat) r_stim <= r_stim + 1'b1;
                end
                DONE: begin
                    if (start) begin
                        r_stim <= '0;
                        r_err  <= '0;
                    end
                end
                default: begin
                    r_stim <= '0;
                    r_err  <= '0;
                end
            endcase
        end
    end

`ifdef GATE_BIST_LOG_EN
    logic [N-1:0] r_ff_pat;
    logic         r_ff_vld;

    // Only the first mismatch of a sweep is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_pat <= '0;
            r_ff_vld <= 1'b0;
        end else if (w_start_ok) begin
            r_ff_pat <= '0;
            r_ff_vld <= 1'b0;
        end else if ((r_state == CHECK) && w_mismatch && !r_ff_vld) begin
            r_ff_pat <= r_stim;
            r_ff_vld <= 1'b1;
        end
    end

    assign first_fail_pat = r_ff_pat;
    assign first_fail_vld = r_ff_vld;
`endif

    assign stim      = r_stim;
    assign err_count = r_err;
    assign busy      = (r_state == APPLY) || (r_state == SETTLE) || (r_state == CHECK);
    assign done      = (r_state == DONE);
    assign pass      = (r_state == DONE) && (r_err == '0);

endmodule
`default_nettype wire

// File: tb/tb_gate_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_bist
// Brief    : Self-checking bench for gate_bist: table-driven and random fault
//            masks against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_bist;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] mask;
    logic [3:0]  stim;
    logic        dut_y;
    logic        busy, done, pass;
    logic [7:0]  err_count;

    logic [3:0]  sat_stim;
    logic        sat_busy, sat_done, sat_pass;
    logic [2:0]  sat_err;

    logic [7:0]  fn_mask [4];
    logic [2:0]  fn_stim [4];
    logic        fn_y    [4];
    logic        fn_busy [4];
    logic        fn_done [4];
    logic        fn_pass [4];
    logic [3:0]  fn_err  [4];
    int          fn_edge [4];

`ifdef GATE_BIST_LOG_EN
    logic [3:0]  ffp;
    logic        ffv;
    logic [3:0]  sat_ffp;
    logic        sat_ffv;
    logic [2:0]  fn_ffp [4];
    logic        fn_ffv [4];
`endif

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference gate behaviour from truth-table rules, plus per-pattern fault flips.
    function automatic logic fn_ref(int f, logic [2:0] v);
        case (f)
            0:       return (v != 3'd0);
            1:       return (v == 3'd7);
            2:       return ($countones(v) % 2) == 1;
            default: return (v == 3'd0);
        endcase
    endfunction

    assign dut_y = (stim != 4'd0) ^ mask[stim];

    gate_bist u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef GATE_BIST_LOG_EN
        , .first_fail_pat(ffp), .first_fail_vld(ffv)
`endif
    );

    gate_bist #(.ERR_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(sat_stim), .dut_y(1'b0),
        .busy(sat_busy), .done(sat_done), .pass(sat_pass), .err_count(sat_err)
`ifdef GATE_BIST_LOG_EN
        , .first_fail_pat(sat_ffp), .first_fail_vld(sat_ffv)
`endif
    );

    for (genvar f = 0; f < 4; f++) begin : g_fn
        assign fn_y[f] = fn_ref(f, fn_stim[f]) ^ fn_mask[f][fn_stim[f]];
        gate_bist #(.N(3), .FUNC(f), .SETTLE_CYCLES(2), .ERR_W(4)) u_fn (
            .clk(clk), .rst_n(rst_n), .start(start), .stim(fn_stim[f]), .dut_y(fn_y[f]),
            .busy(fn_busy[f]), .done(fn_done[f]), .pass(fn_pass[f]), .err_count(fn_err[f])
`ifdef GATE_BIST_LOG_EN
            , .first_fail_pat(fn_ffp[f]), .first_fail_vld(fn_ffv[f])
`endif
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int popcount(logic [15:0] m);
        int c = 0;
        for (int i = 0; i < 16; i++) if (m[i]) c++;
        return c;
    endfunction

    function automatic int lowest(logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return 0;
    endfunction

    // One full sweep; poke>0 re-pulses start so it is sampled at edge 'poke'.
    task automatic run_sweep(input logic [15:0] m, input int poke, output int dedge);
        mask = m;
        for (int f = 0; f < 4; f++) fn_mask[f] = 8'($urandom_range(0, 255));
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
        check("err_cleared", {24'd0, err_count}, 32'd0);
        check("stim_cleared", {28'd0, stim}, 32'd0);
        dedge = -1;
        for (int f = 0; f < 4; f++) fn_edge[f] = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            @(negedge clk);
            start = (poke > 0) && (e == poke - 1);
            for (int f = 0; f < 4; f++) if (fn_done[f] && fn_edge[f] < 0) fn_edge[f] = e;
            if (done) begin
                dedge = e;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_sweep(input int dedge, input int exp_err, input logic exp_pass,
                               input int exp_ffp, input logic exp_ffv);
        check("done_edge", dedge, 32'd48);
        check("err_count", {24'd0, err_count}, exp_err);
        check("pass", {31'd0, pass}, {31'd0, exp_pass});
        check("stim_final", {28'd0, stim}, 32'hF);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("sat_err", {29'd0, sat_err}, 32'd7);
        check("sat_pass", {31'd0, sat_pass}, 32'd0);
`ifdef GATE_BIST_LOG_EN
        check("ff_vld", {31'd0, ffv}, {31'd0, exp_ffv});
        if (exp_ffv) check("ff_pat", {28'd0, ffp}, exp_ffp);
        check("sat_ff_pat", {28'd0, sat_ffp}, 32'd1);
`endif
        for (int f = 0; f < 4; f++) begin
            check($sformatf("fn%0d_done_edge", f), fn_edge[f], 32'd32);
            check($sformatf("fn%0d_err", f), {28'd0, fn_err[f]}, popcount({8'd0, fn_mask[f]}));
            check($sformatf("fn%0d_pass", f), {31'd0, fn_pass[f]}, {31'd0, fn_mask[f] == 8'd0});
            check($sformatf("fn%0d_stim", f), {29'd0, fn_stim[f]}, 32'd7);
`ifdef GATE_BIST_LOG_EN
            check($sformatf("fn%0d_ff_vld", f), {31'd0, fn_ffv[f]}, {31'd0, fn_mask[f] != 8'd0});
            if (fn_mask[f] != 8'd0)
                check($sformatf("fn%0d_ff_pat", f), {29'd0, fn_ffp[f]}, lowest({8'd0, fn_mask[f]}));
`endif
        end
    endtask

    typedef struct {
        logic [15:0] m;
        int          poke;
        int          exp_err;
        logic        exp_pass;
        int          exp_ffp;
        logic        exp_ffv;
    } vec_t;

    initial begin
        vec_t vecs [4];
        int   dedge;
        logic seen_done, seen_busy;

        // correct OR, stuck-at-0, stuck-at-1 with an ignored start, restart after a fail
        vecs[0] = '{16'h0000, 0,  0,  1'b1, 0, 1'b0};
        vecs[1] = '{16'hFFFE, 0,  15, 1'b0, 1, 1'b1};
        vecs[2] = '{16'h0001, 10, 1,  1'b0, 0, 1'b1};
        vecs[3] = '{16'h0000, 0,  0,  1'b1, 0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        mask  = '0;
        for (int f = 0; f < 4; f++) fn_mask[f] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        check("rst_stim", {28'd0, stim}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_sweep(vecs[i].m, vecs[i].poke, dedge);
            check_sweep(dedge, vecs[i].exp_err, vecs[i].exp_pass, vecs[i].exp_ffp, vecs[i].exp_ffv);
        end

        for (int i = 0; i < 6; i++) begin
            logic [15:0] m;
            int          poke;
            m = 16'($urandom);
            if (i % 2 == 1) m = m & 16'($urandom);
            if (i == 0) m = 16'h8000;
            poke = (i % 3 == 0) ? int'($urandom_range(2, 47)) : 0;
            run_sweep(m, poke, dedge);
            check_sweep(dedge, popcount(m), m == 16'd0, lowest(m), m != 16'd0);
        end

        // Reset mid-sweep: outputs drop at once, no done afterwards.
        mask = 16'hFFFF;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("err_before_rst", {24'd0, err_count}, 32'd6);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_stim", {28'd0, stim}, 32'd0);
        check("async_rst_err", {24'd0, err_count}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (60) begin
            @(negedge clk);
            seen_done = seen_done | done;
            seen_busy = seen_busy | busy;
        end
        check("no_done_after_rst", {31'd0, seen_done}, 32'd0);
        check("idle_after_rst", {31'd0, seen_busy}, 32'd0);
        check("idle_stim", {28'd0, stim}, 32'd0);

        run_sweep(16'h0000, 0, dedge);
        check_sweep(dedge, 0, 1'b1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
